// File: rtl/text_raster.sv
// Raster timing generator and 8x16 glyph renderer for a 160x64 character buffer.
// Counter position (h,v) reaches the pixel/sync outputs exactly four clocks later.
module text_raster #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  char_row,
  output logic [7:0]  char_col,
  input  logic [7:0]  char_code,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int unsigned CW      = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC - 1;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC - 1;

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          h_last;
  logic          v_last;

  logic de_s0;
  logic hs_s0;
  logic vs_s0;
  logic fs_s0;

  logic [2:0] de_p;
  logic [2:0] hs_p;
  logic [2:0] vs_p;
  logic [2:0] fs_p;
  logic [2:0] hlo_d1;
  logic [2:0] hlo_d2;
  logic [2:0] hlo_d3;
  logic [3:0] vlo_d1;

  logic [6:0] shreg;
  logic [7:0] shreg_nxt;

  assign h_last = (hcnt == CW'(H_TOTAL - 1));
  assign v_last = (vcnt == CW'(V_TOTAL - 1));

  // Pixel and line counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + CW'(1);
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  // Stage-0 timing flags from the registered counters
  always_comb begin
    de_s0 = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
    hs_s0 = (hcnt >= CW'(HS_BEG)) && (hcnt <= CW'(HS_END));
    vs_s0 = (vcnt >= CW'(VS_BEG)) && (vcnt <= CW'(VS_END));
    fs_s0 = (hcnt == '0) && (vcnt == '0);
  end

  // Buffer address, clamped to cell (0,0) during blanking
  always_comb begin
    char_col = 8'd0;
    char_row = 8'd0;
    if (de_s0) begin
      char_col = hcnt[10:3];
      char_row = {2'b00, vcnt[9:4]};
    end
  end

  // Timing and sub-cell position pipelines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p   <= '0;
      hs_p   <= '0;
      vs_p   <= '0;
      fs_p   <= '0;
      hlo_d1 <= '0;
      hlo_d2 <= '0;
      hlo_d3 <= '0;
      vlo_d1 <= '0;
    end else begin
      de_p   <= {de_p[1:0], de_s0};
      hs_p   <= {hs_p[1:0], hs_s0};
      vs_p   <= {vs_p[1:0], vs_s0};
      fs_p   <= {fs_p[1:0], fs_s0};
      hlo_d1 <= hcnt[2:0];
      hlo_d2 <= hlo_d1;
      hlo_d3 <= hlo_d2;
      vlo_d1 <= vcnt[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_addr <= '0;
    end else begin
      font_addr <= {char_code, vlo_d1};
    end
  end

  // Glyph row loads on the first pixel of each cell; only the 7 pending bits are kept
  assign shreg_nxt = (hlo_d3 == 3'd0) ? font_data : {shreg, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      pixel       <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      shreg       <= shreg_nxt[6:0];
      pixel       <= shreg_nxt[7] & de_p[2];
      de          <= de_p[2];
      hsync       <= hs_p[2] ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_p[2] ? SYNC_POL : ~SYNC_POL;
      frame_start <= fs_p[2];
    end
  end

endmodule

// File: tb/tb_text_raster.sv
// Bench for text_raster: a full-size instance for line timing and a shrunk instance
// for whole-frame, last-cell and mid-frame reset behaviour, both against a pixel-position model.
module tb_text_raster;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] vram [64][160];
  logic [7:0] rom  [4096];

  logic        rst_f, rst_s;
  logic [7:0]  row_f, col_f, code_f, fdat_f, row_s, col_s, code_s, fdat_s;
  logic [11:0] addr_f, addr_s;
  logic        pix_f, de_f, hs_f, vs_f, fs_f;
  logic        pix_s, de_s, hs_s, vs_s, fs_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  text_raster dut_f (
    .clk(clk), .rst_n(rst_f), .char_row(row_f), .char_col(col_f), .char_code(code_f),
    .font_addr(addr_f), .font_data(fdat_f), .pixel(pix_f), .de(de_f), .hsync(hs_f),
    .vsync(vs_f), .frame_start(fs_f)
  );

  text_raster #(
    .H_ACTIVE(48), .H_FP(4), .H_SYNC(8), .H_BP(12),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(3), .V_BP(4), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .char_row(row_s), .char_col(col_s), .char_code(code_s),
    .font_addr(addr_s), .font_data(fdat_s), .pixel(pix_s), .de(de_s), .hsync(hs_s),
    .vsync(vs_s), .frame_start(fs_s)
  );

  // Synchronous buffer and font ROM, one clock of read latency each
  always @(posedge clk) begin
    code_f <= vram[row_f[5:0]][col_f];
    code_s <= vram[row_s[5:0]][col_s];
    fdat_f <= rom[addr_f];
    fdat_s <= rom[addr_s];
  end

  // Expected {pixel,de,hsync,vsync,frame_start} k clocks after reset release
  function automatic logic [15:0] exp_out(int k, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
    int p, h, v, ht, vt;
    logic [7:0] c, g;
    logic dv, px;
    if (k < 4) return 16'h0;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = k - 4;
    h  = p % ht;
    v  = (p / ht) % vt;
    dv = (h < ha) && (v < va);
    px = 1'b0;
    if (dv) begin
      c  = vram[v / 16][h / 8];
      g  = rom[{c, 4'(v % 16)}];
      px = g[7 - (h % 8)];
    end
    return {11'd0, px, dv, (h >= ha + hf) && (h < ha + hf + hs),
            (v >= va + vf) && (v < va + vf + vs), (h == 0) && (v == 0)};
  endfunction

  // Expected {char_row,char_col} for the counter position k clocks after release
  function automatic logic [15:0] exp_addr(int k, int ha, int ht, int va, int vt);
    int h, v;
    h = k % ht;
    v = (k / ht) % vt;
    if ((h < ha) && (v < va)) return {8'(v / 16), 8'(h / 8)};
    return 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  localparam int SMALL_RST_K = 2880 + 20 * 72 + 30;

  initial begin
    int kf, ks, hold;
    bit did_rst;
    logic [7:0] rc;

    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 160; c++) begin
        rc = 8'($urandom_range(0, 255));
        if (rc == 8'hFE) rc = 8'h20;
        vram[r][c] = rc;
      end
    for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom_range(0, 255));
    vram[0][0]  = 8'h41;
    rom[12'h410] = 8'hA5;
    // Last cell of the shrunk grid: glyph lit only at its bottom-right pixel
    vram[1][5] = 8'hFE;
    for (int l = 0; l < 16; l++) rom[{8'hFE, 4'(l)}] = (l == 15) ? 8'h01 : 8'h00;

    rst_f = 1'b0;
    rst_s = 1'b0;
    kf = 0; ks = 0; hold = 0; did_rst = 1'b0;

    for (cyc = 0; cyc < 10000 && failures <= 50; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        rst_f = 1'b1;
        rst_s = 1'b1;
      end
      if (!did_rst && ks == SMALL_RST_K) begin
        rst_s   = 1'b0;
        hold    = 3;
        did_rst = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) rst_s = 1'b1;
      end
      if (!rst_s) ks = 0;
      if (!rst_f) kf = 0;
      #1;
      chk("full_out", {11'd0, pix_f, de_f, hs_f, vs_f, fs_f},
          exp_out(kf, 1280, 48, 112, 248, 1024, 1, 3, 38));
      chk("full_addr", {row_f, col_f}, exp_addr(kf, 1280, 1688, 1024, 1066));
      chk("small_out", {11'd0, pix_s, de_s, hs_s, vs_s, fs_s},
          exp_out(ks, 48, 4, 8, 12, 32, 1, 3, 4));
      chk("small_addr", {row_s, col_s}, exp_addr(ks, 48, 72, 32, 40));
      if (!rst_f) chk("full_faddr_rst", {4'd0, addr_f}, 16'h0);
      if (!rst_s) chk("small_faddr_rst", {4'd0, addr_s}, 16'h0);
      @(posedge clk);
      if (rst_f) kf++;
      if (rst_s) ks++;
    end

    if (!did_rst) chk("small_midframe_reset_reached", 16'(did_rst), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
